// File: rtl/counter_updown_mod.sv
// counter_updown_mod: parametrised up/down modulo counter with parallel load,
// wrap or saturate behaviour at the boundaries, a registered terminal-count
// pulse and sticky overflow/underflow flags.
//
// Qualifier semantics: a count step happens on a rising edge only when
// enable && counter_valid are both high in that cycle and neither reset nor
// load is asserted. There is no back-pressure; the counter accepts every
// qualified step. If either qualifier is low, out holds its value.
//
// Legal parameter range: 1 <= MAX_VALUE <= 2^WIDTH-1 and
// RESET_VALUE <= MAX_VALUE.
module counter_updown_mod #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned MAX_VALUE   = 255,
   parameter int unsigned SATURATE    = 0,
   parameter int unsigned RESET_VALUE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             counter_valid,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             clear_flags,
   output logic [WIDTH-1:0] out,
   output logic             terminal,
   output logic             overflow,
   output logic             underflow,
   output logic             at_max,
   output logic             at_min
);

   // All compares and arithmetic stay at WIDTH bits; with
   // MAX_VALUE = 2^WIDTH-1 the wrap is plain binary rollover.
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);
   localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
   localparam logic             SAT   = (SATURATE != 0);

   logic [WIDTH-1:0] count_q;
   logic             term_q;
   logic             ovf_q;
   logic             unf_q;

   logic             step;
   logic             is_max;
   logic             is_min;
   logic             up_event;
   logic             down_event;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] step_value;
   logic [WIDTH-1:0] next_count;
   logic             next_term;
   logic             next_ovf;
   logic             next_unf;

   // Qualified step and boundary detection; load suppresses stepping.
   always_comb begin
      is_max     = (count_q == MAX_V);
      is_min     = (count_q == '0);
      step       = enable && counter_valid && !load;
      up_event   = step && up_down && is_max;
      down_event = step && !up_down && is_min;
   end

   // Load values above MAX_VALUE are clamped to MAX_VALUE.
   always_comb begin
      load_clamped = load_value;
      if (load_value > MAX_V) begin
         load_clamped = MAX_V;
      end
   end

   // Value after one step in the sampled direction, including the
   // wrap/hold choice at the boundaries.
   always_comb begin
      step_value = count_q;
      if (up_down) begin
         if (is_max) begin
            step_value = SAT ? MAX_V : '0;
         end else begin
            step_value = count_q + ONE;
         end
      end else begin
         if (is_min) begin
            step_value = SAT ? '0 : MAX_V;
         end else begin
            step_value = count_q - ONE;
         end
      end
   end

   // Next-state selection: load over step over hold; a boundary event
   // setting a flag wins over a coincident clear of that flag.
   always_comb begin
      next_count = count_q;
      if (load) begin
         next_count = load_clamped;
      end else if (step) begin
         next_count = step_value;
      end
      next_term = up_event || down_event;
      next_ovf  = up_event || (ovf_q && !clear_flags);
      next_unf  = down_event || (unf_q && !clear_flags);
   end

   // State registers with synchronous, highest-priority reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= RST_V;
         term_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= next_count;
         term_q  <= next_term;
         ovf_q   <= next_ovf;
         unf_q   <= next_unf;
      end
   end

   // Registered outputs plus zero-delay boundary indicators.
   assign out       = count_q;
   assign terminal  = term_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   assign at_max    = (count_q == MAX_V);
   assign at_min    = (count_q == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// tb_counter_updown_mod: drives five differently parametrised counters with
// one shared stimulus stream and checks each against a behavioural model.
module tb_counter_updown_mod;

   localparam int N = 5;

   // Per-instance configuration: max value, saturate, reset value, width.
   int mx_p [N] = '{255, 9, 9, 100, 100};
   int sat_p[N] = '{0,   0, 1, 0,   1};
   int rv_p [N] = '{0,   0, 0, 5,   0};
   int w_p  [N] = '{8,   4, 4, 8,   8};

   // Clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       counter_valid = 1'b0;
   logic       up_down = 1'b1;
   logic       load = 1'b0;
   logic [7:0] load_value = 8'd0;
   logic       clear_flags = 1'b0;

   logic [7:0] o0, o3, o4;
   logic [3:0] o1, o2;
   logic [N-1:0] t_v, ov_v, un_v, amx_v, amn_v;
   logic [7:0] obs_out [N];

   assign obs_out[0] = o0;
   assign obs_out[1] = {4'd0, o1};
   assign obs_out[2] = {4'd0, o2};
   assign obs_out[3] = o3;
   assign obs_out[4] = o4;

   counter_updown_mod #(.WIDTH(8), .MAX_VALUE(255), .SATURATE(0), .RESET_VALUE(0)) u0 (
      .clk(clk), .reset(reset), .enable(enable), .counter_valid(counter_valid),
      .up_down(up_down), .load(load), .load_value(load_value), .clear_flags(clear_flags),
      .out(o0), .terminal(t_v[0]), .overflow(ov_v[0]), .underflow(un_v[0]),
      .at_max(amx_v[0]), .at_min(amn_v[0]));

   counter_updown_mod #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(0), .RESET_VALUE(0)) u1 (
      .clk(clk), .reset(reset), .enable(enable), .counter_valid(counter_valid),
      .up_down(up_down), .load(load), .load_value(load_value[3:0]), .clear_flags(clear_flags),
      .out(o1), .terminal(t_v[1]), .overflow(ov_v[1]), .underflow(un_v[1]),
      .at_max(amx_v[1]), .at_min(amn_v[1]));

   counter_updown_mod #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1), .RESET_VALUE(0)) u2 (
      .clk(clk), .reset(reset), .enable(enable), .counter_valid(counter_valid),
      .up_down(up_down), .load(load), .load_value(load_value[3:0]), .clear_flags(clear_flags),
      .out(o2), .terminal(t_v[2]), .overflow(ov_v[2]), .underflow(un_v[2]),
      .at_max(amx_v[2]), .at_min(amn_v[2]));

   counter_updown_mod #(.WIDTH(8), .MAX_VALUE(100), .SATURATE(0), .RESET_VALUE(5)) u3 (
      .clk(clk), .reset(reset), .enable(enable), .counter_valid(counter_valid),
      .up_down(up_down), .load(load), .load_value(load_value), .clear_flags(clear_flags),
      .out(o3), .terminal(t_v[3]), .overflow(ov_v[3]), .underflow(un_v[3]),
      .at_max(amx_v[3]), .at_min(amn_v[3]));

   counter_updown_mod #(.WIDTH(8), .MAX_VALUE(100), .SATURATE(1), .RESET_VALUE(0)) u4 (
      .clk(clk), .reset(reset), .enable(enable), .counter_valid(counter_valid),
      .up_down(up_down), .load(load), .load_value(load_value), .clear_flags(clear_flags),
      .out(o4), .terminal(t_v[4]), .overflow(ov_v[4]), .underflow(un_v[4]),
      .at_max(amx_v[4]), .at_min(amn_v[4]));

   // Scoreboard state
   int checks = 0;
   int errors = 0;
   int m_out [N];
   int m_term[N];
   int m_ovf [N];
   int m_unf [N];

   task automatic check(input string tag, input int idx, input logic [7:0] obs,
                        input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[u%0d] observed %0h expected %0h", tag, idx, obs, exp);
      end
   endtask

   // Reference model: one edge of every counter from the currently driven inputs.
   task automatic model_edge();
      for (int i = 0; i < N; i++) begin
         int lv;
         int up_evt;
         int dn_evt;
         up_evt = 0;
         dn_evt = 0;
         if (reset) begin
            m_out[i] = rv_p[i];
            m_term[i] = 0;
            m_ovf[i] = 0;
            m_unf[i] = 0;
         end else begin
            if (load) begin
               lv = int'(load_value) % (1 << w_p[i]);
               m_out[i] = (lv > mx_p[i]) ? mx_p[i] : lv;
            end else if (enable && counter_valid) begin
               if (up_down) begin
                  if (m_out[i] == mx_p[i]) begin
                     up_evt = 1;
                     m_out[i] = sat_p[i] ? mx_p[i] : 0;
                  end else begin
                     m_out[i] = m_out[i] + 1;
                  end
               end else begin
                  if (m_out[i] == 0) begin
                     dn_evt = 1;
                     m_out[i] = sat_p[i] ? 0 : mx_p[i];
                  end else begin
                     m_out[i] = m_out[i] - 1;
                  end
               end
            end
            m_term[i] = up_evt | dn_evt;
            m_ovf[i] = up_evt ? 1 : (clear_flags ? 0 : m_ovf[i]);
            m_unf[i] = dn_evt ? 1 : (clear_flags ? 0 : m_unf[i]);
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < N; i++) begin
         check("out",       i, obs_out[i],        8'(m_out[i]));
         check("terminal",  i, {7'd0, t_v[i]},    8'(m_term[i]));
         check("overflow",  i, {7'd0, ov_v[i]},   8'(m_ovf[i]));
         check("underflow", i, {7'd0, un_v[i]},   8'(m_unf[i]));
         check("at_max",    i, {7'd0, amx_v[i]},  8'(m_out[i] == mx_p[i]));
         check("at_min",    i, {7'd0, amn_v[i]},  8'(m_out[i] == 0));
      end
   endtask

   // Driver: advance one edge, update model, sample 1 ns later.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      // 1. Reset and gating
      reset = 1'b1;
      ticks(2);
      check("t1_reset_out", 0, o0, 8'd0);
      reset = 1'b0; enable = 1'b1; counter_valid = 1'b0; up_down = 1'b1;
      ticks(5);
      check("t1_gated_out", 0, o0, 8'd0);
      counter_valid = 1'b1;
      ticks(5);
      check("t1_count_out", 0, o0, 8'd5);

      // 2. Modulo wrap up (MAX_VALUE=9, wrap)
      reset = 1'b1;
      tick();
      reset = 1'b0;
      ticks(9);
      check("t2_at9_out", 1, {4'd0, o1}, 8'd9);
      check("t2_at9_term", 1, {7'd0, t_v[1]}, 8'd0);
      tick();
      check("t2_wrap_out", 1, {4'd0, o1}, 8'd0);
      check("t2_wrap_term", 1, {7'd0, t_v[1]}, 8'd1);
      check("t2_wrap_ovf", 1, {7'd0, ov_v[1]}, 8'd1);
      enable = 1'b0;
      tick();
      check("t2_hold_term", 1, {7'd0, t_v[1]}, 8'd0);
      check("t2_sticky_ovf", 1, {7'd0, ov_v[1]}, 8'd1);
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
      check("t2_clear_ovf", 1, {7'd0, ov_v[1]}, 8'd0);

      // 3. Saturating down (MAX_VALUE=9, saturate)
      load = 1'b1; load_value = 8'd2;
      tick();
      load = 1'b0; enable = 1'b1; up_down = 1'b0;
      ticks(3);
      check("t3_sat_out", 2, {4'd0, o2}, 8'd0);
      check("t3_sat_term1", 2, {7'd0, t_v[2]}, 8'd1);
      tick();
      check("t3_sat_term2", 2, {7'd0, t_v[2]}, 8'd1);
      check("t3_unf", 2, {7'd0, un_v[2]}, 8'd1);
      check("t3_at_min", 2, {7'd0, amn_v[2]}, 8'd1);

      // 4. Load precedence and clamp (MAX_VALUE=100, RESET_VALUE=5)
      reset = 1'b1;
      tick();
      reset = 1'b0; up_down = 1'b1;
      ticks(3);
      load = 1'b1; load_value = 8'd200;
      tick();
      check("t4_clamp_out", 3, o3, 8'd100);
      check("t4_load_term", 3, {7'd0, t_v[3]}, 8'd0);
      check("t4_at_max", 3, {7'd0, amx_v[3]}, 8'd1);
      load = 1'b0;
      tick();
      check("t4_wrap_out", 3, o3, 8'd0);
      check("t4_wrap_term", 3, {7'd0, t_v[3]}, 8'd1);
      check("t4_wrap_ovf", 3, {7'd0, ov_v[3]}, 8'd1);

      // 5. Simultaneous set and clear
      enable = 1'b0; clear_flags = 1'b1;
      tick();
      check("t5_cleared", 3, {7'd0, ov_v[3]}, 8'd0);
      clear_flags = 1'b0; load = 1'b1; load_value = 8'd200;
      tick();
      load = 1'b0; enable = 1'b1; clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
      check("t5_set_wins", 3, {7'd0, ov_v[3]}, 8'd1);

      // 6. Reset mid-operation (RESET_VALUE=5)
      enable = 1'b0; load = 1'b1; load_value = 8'd37;
      tick();
      check("t6_at37", 3, o3, 8'd37);
      reset = 1'b1; load = 1'b1; load_value = 8'd77; enable = 1'b1; up_down = 1'b1;
      tick();
      check("t6_reset_out", 3, o3, 8'd5);
      check("t6_reset_term", 3, {7'd0, t_v[3]}, 8'd0);
      reset = 1'b0; load = 1'b0;
      tick();
      check("t6_resume_out", 3, o3, 8'd6);

      // Randomized phase against the model
      for (int c = 0; c < 600; c++) begin
         reset         = ($urandom_range(0, 49) == 0);
         load          = ($urandom_range(0, 9) == 0);
         load_value    = 8'($urandom_range(0, 255));
         clear_flags   = ($urandom_range(0, 7) == 0);
         enable        = ($urandom_range(0, 3) != 0);
         counter_valid = ($urandom_range(0, 3) != 0);
         up_down       = 1'($urandom_range(0, 1));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
Parametrised up/down modulo counter. It is the next generation of the team's 8-bit enable/valid-gated counter. It adds:
- configurable width and modulus
- direction control
- parallel load
- wrap or saturate mode
- a terminal-count pulse and sticky overflow/underflow flags

It sits wherever the design needs event counting, timeouts or index generation, and replaces the fixed 8-bit up-counter.

Parameters:
WIDTH, 8, counter width in bits.
MAX_VALUE, 255, highest count value (inclusive); legal range 1 .. 2^WIDTH-1.
SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries.
RESET_VALUE, 0, value loaded on reset; must be <= MAX_VALUE.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
enable  input  1  count enable.
counter_valid  input  1  count qualifier; a count step happens only when enable && counter_valid.
up_down  input  1  1 = increment, 0 = decrement.
load  input  1  synchronous parallel load.
load_value  input  WIDTH  value for load.
clear_flags  input  1  clears the overflow and underflow flags.
out  output  WIDTH  current count (registered).
terminal  output  1  one-cycle pulse marking a boundary event (registered).
overflow  output  1  sticky: an up-count hit MAX_VALUE's boundary.
underflow  output  1  sticky: a down-count hit 0's boundary.
at_max  output  1  combinational: out == MAX_VALUE.
at_min  output  1  combinational: out == 0.

Behaviour:
- Single clock domain; all state updates on the rising edge of clk.
- Reset (synchronous, active-high), highest priority:
  - out = RESET_VALUE; terminal = 0; overflow = 0; underflow = 0.
  - Reset asserted mid-count discards any load or step in that cycle.
- Priority per edge: reset > load > count step > hold.
- Load:
  - out = min(load_value, MAX_VALUE); values above MAX_VALUE are clamped.
  - Works regardless of enable and counter_valid.
  - No terminal pulse; flags are unchanged.
- Step condition: enable && counter_valid && !load && !reset. If either enable or counter_valid is low, out holds.
- Up step:
  - out < MAX_VALUE: out + 1.
  - out == MAX_VALUE: boundary event; out becomes 0 (SATURATE=0) or stays MAX_VALUE (SATURATE=1).
- Down step:
  - out > 0: out - 1.
  - out == 0: boundary event; out becomes MAX_VALUE (SATURATE=0) or stays 0 (SATURATE=1).
- Boundary event:
  - terminal = 1 for exactly the one cycle after the event edge.
  - In SATURATE=1, each repeated step at the boundary re-pulses terminal, so terminal can stay high on consecutive cycles.
  - An up event sets overflow; a down event sets underflow.
- Flag clearing:
  - clear_flags clears both sticky flags on the next edge.
  - If a boundary event and clear_flags coincide, the set wins.
- terminal is 0 on any edge without a boundary event, including hold and load cycles.
- Arithmetic: internal next-value compare is done at WIDTH bits; no bits beyond WIDTH are ever produced. With MAX_VALUE = 2^WIDTH-1, wrap equals natural binary rollover.
- A direction change takes effect on the same edge it is sampled; no extra latency.
- Latency: a step or load is visible on out one cycle after the qualifying edge's inputs are sampled. at_max and at_min follow out with zero delay.

Test Plan:
1. Reset and gating (WIDTH=8, MAX_VALUE=255):
   - Stimulus: hold reset for 2 cycles, then enable=1 with counter_valid=0 for 5 cycles.
   - Required: out=0x00 throughout, terminal, overflow and underflow all 0.
   - Then set counter_valid=1 for 5 cycles -> out steps 1, 2, 3, 4, 5.
2. Modulo wrap up (MAX_VALUE=9, SATURATE=0):
   - Stimulus: count up from 0 for 10 steps.
   - Required: out goes 1..9, then 0; terminal high for the single cycle after the 9->0 edge; overflow=1 and stays 1.
   - Then pulse clear_flags -> overflow=0.
3. Saturating down (MAX_VALUE=9, SATURATE=1):
   - Stimulus: load 2, then step down 4 times.
   - Required: out goes 1, 0, 0, 0; terminal is high on the two cycles following each step at 0; underflow=1; at_min=1.
4. Load precedence and clamp (WIDTH=8, MAX_VALUE=100):
   - Stimulus: while counting up, assert load with load_value=200.
   - Required: out=100 next cycle, no terminal pulse, at_max=1.
   - Next up step -> out=0, terminal pulses, overflow=1.
5. Simultaneous set and clear:
   - Stimulus: at out=MAX_VALUE, step up with clear_flags=1 in the same cycle.
   - Required: overflow=1 after the edge.
6. Reset mid-operation:
   - Stimulus: RESET_VALUE=5; at out=37, assert reset with load=1 and a step also active.
   - Required: out=5, all flags 0; counting resumes from 5 next cycle.
